// File: rtl/da_fir_pkg.sv
// Shared types and constants for the multi-channel distributed-arithmetic FIR engine.
package da_fir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_LOAD_RJ,
    S_ACCUM,
    S_FOLD,
    S_DONE,
    S_OUT
  } state_t;

  localparam logic CFG_SEL_RJ   = 1'b0;
  localparam logic CFG_SEL_COEF = 1'b1;

  localparam int unsigned U_GUARD = 8;
  localparam int unsigned FRAC_W  = 16;
  localparam int unsigned U_W     = 16 + U_GUARD;
  localparam int unsigned OUT_W   = U_W + FRAC_W;

  // Coefficient word: bit lag_w is the subtract flag, bits below it are the lag.
  function automatic void coef_unpack(input  logic [31:0] word,
                                      input  int unsigned lag_w,
                                      output logic        sub,
                                      output logic [31:0] lag);
    sub = word[lag_w];
    lag = word & ((32'd1 << lag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/da_fir_history.sv
// Per-channel circular sample history: frame write, read by lag from newest, sync clear.
module da_fir_history #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     we,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [ADDR_W-1:0]        rd_lag,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [ADDR_W-1:0] wr_ptr [NUM_CH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned a = 0; a < DEPTH; a++) mem[c][a] <= '0;
      end
    end else if (clear) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned a = 0; a < DEPTH; a++) mem[c][a] <= '0;
      end
    end else if (we) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]                          <= wr_ptr[c] + ADDR_W'(1);
        mem[c][wr_ptr[c] + ADDR_W'(1)]     <= wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = mem[rd_ch][wr_ptr[rd_ch] - rd_lag];

endmodule

// File: rtl/da_fir_mc.sv
// Multi-channel DA FIR engine: loadable Rj/coefficient tables, sequential channel processing.
module da_fir_mc
  import da_fir_pkg::*;
#(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned ADDR_W  = 8,
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned PREC    = 16,
  parameter  int unsigned COEF_AW = 9,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned UW      = DATA_W + U_GUARD,
  localparam int unsigned OW      = UW + FRAC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cfg_we,
  input  logic                     cfg_sel,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [COEF_AW-1:0]       cfg_addr,
  input  logic [ADDR_W:0]          cfg_data,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*OW-1:0]     out_data
);

  localparam int unsigned JW   = (PREC > 1) ? $clog2(PREC) : 1;
  localparam int unsigned CDEP = 2 ** COEF_AW;

  state_t state, state_nxt;

  logic [7:0]        rj_tab   [NUM_CH][PREC];
  logic [ADDR_W:0]   coef_tab [NUM_CH][CDEP];
  logic [NUM_CH*DATA_W-1:0] sample_q;
  logic [CH_W-1:0]    ch;
  logic [JW-1:0]      j;
  logic [COEF_AW-1:0] m;
  logic [7:0]         r, k;
  logic signed [UW-1:0] u, x_ext;
  logic signed [OW-1:0] y, fold_sum, fold_y;
  logic [OW-1:0]      res [NUM_CH];
  logic               hist_clear, hist_we, tap_sub;
  logic [31:0]        tap_lag;
  logic [DATA_W-1:0]  x;

  da_fir_history #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_hist (
    .clock  (clock),
    .reset  (reset),
    .clear  (hist_clear),
    .we     (hist_we),
    .wdata  (sample_q),
    .rd_ch  (ch),
    .rd_lag (ADDR_W'(tap_lag)),
    .rd_data(x)
  );

  always_comb begin
    tap_sub = 1'b0;
    tap_lag = '0;
    coef_unpack(32'(coef_tab[ch][m]), ADDR_W, tap_sub, tap_lag);
    x_ext    = {{(UW-DATA_W){x[DATA_W-1]}}, x};
    fold_sum = y + {u, {FRAC_W{1'b0}}};
    fold_y   = fold_sum >>> 1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Sample is latched in IDLE and committed in WR, so a same-cycle flush lands first.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    hist_clear = 1'b0;
    hist_we    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready   = 1'b1;
        hist_clear = flush;
        if (in_valid) state_nxt = S_WR;
      end
      S_WR: begin
        hist_we   = 1'b1;
        state_nxt = S_LOAD_RJ;
      end
      S_LOAD_RJ: state_nxt = (rj_tab[ch][j] == '0) ? S_FOLD : S_ACCUM;
      S_ACCUM:   if (k == r - 8'd1) state_nxt = S_FOLD;
      S_FOLD: begin
        if (j != JW'(PREC - 1))         state_nxt = S_LOAD_RJ;
        else if (ch != CH_W'(NUM_CH-1)) state_nxt = S_LOAD_RJ;
        else                            state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      ch       <= '0;
      j        <= '0;
      m        <= '0;
      r        <= '0;
      k        <= '0;
      u        <= '0;
      y        <= '0;
      out_data <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) res[c] <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sample_q <= in_data;
          ch       <= '0;
          j        <= '0;
          m        <= '0;
          y        <= '0;
        end
        S_LOAD_RJ: begin
          r <= rj_tab[ch][j];
          u <= '0;
          k <= '0;
        end
        S_ACCUM: begin
          u <= tap_sub ? u - x_ext : u + x_ext;
          m <= m + COEF_AW'(1);
          k <= k + 8'd1;
        end
        S_FOLD: begin
          if (j != JW'(PREC - 1)) begin
            y <= fold_y;
            j <= j + JW'(1);
          end else begin
            res[ch] <= fold_y;
            if (ch != CH_W'(NUM_CH - 1)) begin
              ch <= ch + CH_W'(1);
              j  <= '0;
              m  <= '0;
              y  <= '0;
            end
          end
        end
        S_DONE: for (int unsigned c = 0; c < NUM_CH; c++) out_data[c*OW +: OW] <= res[c];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_err <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned a = 0; a < PREC; a++) rj_tab[c][a] <= '0;
        for (int unsigned a = 0; a < CDEP; a++) coef_tab[c][a] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && (state != S_IDLE);
      if (cfg_we && state == S_IDLE) begin
        if (cfg_sel == CFG_SEL_RJ) rj_tab[cfg_ch][cfg_addr[JW-1:0]] <= cfg_data[7:0];
        else                       coef_tab[cfg_ch][cfg_addr]       <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_da_fir_mc.sv
// Directed bench for da_fir_mc: table-driven frames plus backpressure, multi-term and reset sequences.
module tb_da_fir_mc;
  import da_fir_pkg::*;

  logic        clock = 1'b0;
  logic        reset, flush, cfg_we, cfg_sel, cfg_err;
  logic [0:0]  cfg_ch;
  logic [8:0]  cfg_addr, cfg_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data;
  logic [2*OUT_W-1:0] out_data;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic        fl;
    logic [8:0]  coef;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [39:0] exp0;
    logic [39:0] exp1;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  da_fir_mc #(
    .DATA_W (16),
    .ADDR_W (8),
    .NUM_CH (2),
    .PREC   (16),
    .COEF_AW(9)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_ch   (cfg_ch),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cfg_write(input logic sel, input logic ch, input logic [8:0] addr,
                           input logic [8:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send(input string name, input logic [15:0] x0, input logic [15:0] x1);
    in_data  = {x1, x0};
    in_valid = 1'b1;
    check({name, "/in_ready"}, 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [39:0] exp0, input logic [39:0] exp1,
                          input int unsigned lat);
    int unsigned cnt = 0;
    while (out_valid !== 1'b1 && cnt < 400) begin
      cyc();
      cnt++;
    end
    check({name, "/latency"}, 64'(cnt), 64'(lat));
    check({name, "/out0"}, 64'(out_data[0 +: 40]), 64'(exp0));
    check({name, "/out1"}, 64'(out_data[40 +: 40]), 64'(exp1));
    if (out_ready) begin
      cyc();
      check({name, "/valid_1cyc"}, 64'(out_valid), 64'd0);
      check({name, "/idle"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 9'h000, 16'h4000, 16'h0000, 40'h0020000000, 40'h0};
    vecs[1] = '{1'b0, 9'h100, 16'h0001, 16'h0000, 40'hFFFFFF8000, 40'h0};
    vecs[2] = '{1'b1, 9'h002, 16'h0100, 16'h0000, 40'h0000000000, 40'h0};
    vecs[3] = '{1'b0, 9'h002, 16'h0000, 16'h0000, 40'h0000000000, 40'h0};
    vecs[4] = '{1'b0, 9'h002, 16'h0000, 16'h0000, 40'h0000800000, 40'h0};
    vecs[5] = '{1'b0, 9'h001, 16'h7FFF, 16'h0000, 40'h0000000000, 40'h0};
    vecs[6] = '{1'b0, 9'h101, 16'h1234, 16'h0000, 40'hFFC0008000, 40'h0};
    vecs[7] = '{1'b0, 9'h000, 16'h8000, 16'h0000, 40'hFFC0000000, 40'h0};

    reset = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0;
    cfg_addr = '0; cfg_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_data", 64'(out_data[63:0]), 64'd0);
    check("rst/cfg_err", 64'(cfg_err), 64'd0);
    reset = 1'b1;
    cyc();
    check("rst/in_ready", 64'(in_ready), 64'd1);

    // Table-driven frames: ch0 single tap in group 15, ch1 unloaded.
    cfg_write(CFG_SEL_RJ, 1'b0, 9'd15, 9'd1);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].fl) begin
        flush = 1'b1;
        cyc();
        flush = 1'b0;
      end
      cfg_write(CFG_SEL_COEF, 1'b0, 9'd0, vecs[i].coef);
      send($sformatf("v%0d", i), vecs[i].x0, vecs[i].x1);
      wait_out($sformatf("v%0d", i), vecs[i].exp0, vecs[i].exp1, 67);
    end

    // Backpressure with a dropped config write while the result is held.
    out_ready = 1'b0;
    send("bp0", 16'h0100, 16'h0000);
    wait_out("bp0", 40'h0000800000, 40'h0, 67);
    in_data  = {16'h0000, 16'h0200};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cfg_we = (i == 3); cfg_sel = CFG_SEL_RJ; cfg_ch = '0; cfg_addr = 9'd15; cfg_data = 9'd0;
      cyc();
      check($sformatf("bp/hold%0d/out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp/hold%0d/out0", i), 64'(out_data[0 +: 40]), 64'h0000800000);
      check($sformatf("bp/hold%0d/in_ready", i), 64'(in_ready), 64'd0);
      if (i == 3) check("bp/cfg_err_pulse", 64'(cfg_err), 64'd1);
      if (i == 4) check("bp/cfg_err_clear", 64'(cfg_err), 64'd0);
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("bp/released_valid", 64'(out_valid), 64'd0);
    check("bp/released_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    wait_out("bp1", 40'h0001000000, 40'h0, 67);

    // ch1: two-term group 0 (lag 0 and lag 1), shifted PREC times back to unity.
    cfg_write(CFG_SEL_RJ, 1'b1, 9'd0, 9'd2);
    cfg_write(CFG_SEL_COEF, 1'b1, 9'd0, 9'h000);
    cfg_write(CFG_SEL_COEF, 1'b1, 9'd1, 9'h001);
    send("c1a", 16'h0000, 16'h0005);
    wait_out("c1a", 40'h0, 40'h0000000005, 69);
    send("c1b", 16'h0000, 16'hFFFD);
    wait_out("c1b", 40'h0, 40'h0000000002, 69);
    send("c1c", 16'h0000, 16'h8000);
    wait_out("c1c", 40'h0, 40'hFFFFFF7FFD, 69);

    // Reset in ch0 group-15 accumulation; tables and history must be cleared.
    send("ra", 16'h0100, 16'h0000);
    repeat (32) cyc();
    check("ra/busy", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("ra/rst_valid", 64'(out_valid), 64'd0);
    check("ra/rst_data", 64'(out_data[63:0]), 64'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    check("ra/in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("ra/no_valid%0d", i), 64'(out_valid), 64'd0);
    end
    send("rb", 16'h0100, 16'h0000);
    wait_out("rb", 40'h0, 40'h0, 66);
    cfg_write(CFG_SEL_RJ, 1'b0, 9'd15, 9'd1);
    cfg_write(CFG_SEL_COEF, 1'b0, 9'd0, 9'h002);
    send("rc", 16'h0100, 16'h0000);
    wait_out("rc", 40'h0, 40'h0, 67);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
